// File: rtl/rty_pkg.sv
// Shared types and default sizing for the retry grant scheduler and the retry engine.
package rty_pkg;

  localparam int DEF_QOS_CLASS   = 4;
  localparam int DEF_SRC_NODE_W  = 2;
  localparam int DEF_Q_DEPTH     = 4;
  localparam int DEF_MAX_INFLY   = 4;
  localparam int DEF_AGE_LIMIT   = 15;
  localparam int DEF_TIMEOUT_CYC = 100;

  typedef logic [$clog2(DEF_QOS_CLASS)-1:0] qos_t;
  typedef logic [DEF_SRC_NODE_W-1:0]        src_t;

endpackage

// File: rtl/rty_src_fifo.sv
// Single-class FIFO of parked source IDs; pointers carry one wrap bit for full/empty.
module rty_src_fifo
  import rty_pkg::*;
#(
  parameter int DEPTH = DEF_Q_DEPTH,
  parameter int WIDTH = $bits(src_t)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // NOTE: storage is not reset; the pointers alone decide which entries are valid.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr[AW-1:0]] <= wdata;
  end

  assign rdata = mem[rd_ptr[AW-1:0]];
  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

endmodule

// File: rtl/rty_grant_sched.sv
// Retry grant scheduler: per-class parking queues, aged strict-priority arbitration,
// in-flight accounting and per-class watchdog reclaim.
module rty_grant_sched
  import rty_pkg::*;
#(
  parameter int QOS_CLASS   = DEF_QOS_CLASS,
  parameter int SRC_NODE_W  = DEF_SRC_NODE_W,
  parameter int Q_DEPTH     = DEF_Q_DEPTH,
  parameter int MAX_INFLY   = DEF_MAX_INFLY,
  parameter int AGE_LIMIT   = DEF_AGE_LIMIT,
  parameter int TIMEOUT_CYC = DEF_TIMEOUT_CYC
) (
  input  logic                                       clk,
  input  logic                                       rst_n,
  input  logic                                       enq_vld,
  output logic                                       enq_rdy,
  input  logic [$clog2(QOS_CLASS)-1:0]               enq_qos,
  input  logic [SRC_NODE_W-1:0]                      enq_src,
  input  logic [QOS_CLASS-1:0]                       cls_free,
  output logic                                       grant_vld,
  input  logic                                       grant_rdy,
  output logic [$clog2(QOS_CLASS)-1:0]               grant_qos,
  output logic [SRC_NODE_W-1:0]                      grant_des_id,
  input  logic                                       ret_vld,
  input  logic [$clog2(QOS_CLASS)-1:0]               ret_qos,
  output logic [QOS_CLASS*($clog2(MAX_INFLY)+1)-1:0] infly_cnt,
  output logic                                       tmo_pulse,
  output logic [$clog2(QOS_CLASS)-1:0]               tmo_qos,
  output logic                                       ret_err
);

  localparam int QW = $clog2(QOS_CLASS);
  localparam int CW = $clog2(MAX_INFLY) + 1;
  localparam int AW = $clog2(AGE_LIMIT + 1);
  localparam int WW = $clog2(TIMEOUT_CYC);

  logic [QOS_CLASS-1:0]  q_full, q_empty, q_push, q_pop;
  logic [QOS_CLASS-1:0]  elig, aged, ret_hit, expire, inf_dec, tmo_fire;
  logic [SRC_NODE_W-1:0] q_head [QOS_CLASS];
  logic [CW-1:0]         infly  [QOS_CLASS];
  logic [AW-1:0]         age    [QOS_CLASS];
  logic [WW-1:0]         wd     [QOS_CLASS];
  logic                  load_open, any_elig, tmo_any;
  logic [QW-1:0]         win, tmo_cls;

  assign load_open = !grant_vld || grant_rdy;
  assign enq_rdy   = !q_full[enq_qos];

  for (genvar g = 0; g < QOS_CLASS; g++) begin : g_cls
    rty_src_fifo #(.DEPTH(Q_DEPTH), .WIDTH(SRC_NODE_W)) u_fifo (
      .clk   (clk),
      .rst_n (rst_n),
      .push  (q_push[g]),
      .wdata (enq_src),
      .pop   (q_pop[g]),
      .rdata (q_head[g]),
      .full  (q_full[g]),
      .empty (q_empty[g])
    );

    assign q_push[g]   = enq_vld && enq_rdy && (enq_qos == QW'(g));
    assign elig[g]     = !q_empty[g] && cls_free[g] && (infly[g] < CW'(MAX_INFLY));
    assign aged[g]     = elig[g] && (age[g] == AW'(AGE_LIMIT));
    assign q_pop[g]    = load_open && any_elig && (win == QW'(g));
    assign ret_hit[g]  = ret_vld && (ret_qos == QW'(g));
    // A return landing in the expiry cycle pre-empts the reclaim.
    assign expire[g]   = (wd[g] == WW'(TIMEOUT_CYC - 1)) && !ret_hit[g];
    assign tmo_fire[g] = tmo_any && (tmo_cls == QW'(g));
    assign inf_dec[g]  = (ret_hit[g] && (infly[g] != '0)) || tmo_fire[g];
    assign infly_cnt[g*CW +: CW] = infly[g];
  end

  // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    any_elig = |elig;
    win      = '0;
    tmo_any  = 1'b0;
    tmo_cls  = '0;
    // Ascending scans let the highest matching index overwrite; aged classes override.
    for (int i = 0; i < QOS_CLASS; i++) if (elig[i]) win = QW'(i);
    if (|aged) begin
      for (int i = 0; i < QOS_CLASS; i++) if (aged[i]) win = QW'(i);
    end
    for (int i = QOS_CLASS - 1; i >= 0; i--) begin
      if (expire[i]) begin
        tmo_any = 1'b1;
        tmo_cls = QW'(i);
      end
    end
  end

  // NOTE: non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      grant_vld    <= 1'b0;
      grant_qos    <= '0;
      grant_des_id <= '0;
      tmo_pulse    <= 1'b0;
      tmo_qos      <= '0;
      ret_err      <= 1'b0;
      for (int i = 0; i < QOS_CLASS; i++) begin
        infly[i] <= '0;
        age[i]   <= '0;
        wd[i]    <= '0;
      end
    end else begin
      if (load_open) begin
        grant_vld <= any_elig;
        if (any_elig) begin
          grant_qos    <= win;
          grant_des_id <= q_head[win];
        end
      end
      tmo_pulse <= tmo_any;
      tmo_qos   <= tmo_cls;
      ret_err   <= ret_vld && (infly[ret_qos] == '0);

      for (int i = 0; i < QOS_CLASS; i++) begin
        if (load_open) begin
          if (!elig[i] || q_pop[i])                age[i] <= '0;
          else if (age[i] != AW'(AGE_LIMIT))       age[i] <= age[i] + 1'b1;
        end

        case ({q_pop[i], inf_dec[i]})
          2'b10:   infly[i] <= infly[i] + 1'b1;
          2'b01:   infly[i] <= infly[i] - 1'b1;
          default: infly[i] <= infly[i];
        endcase

        // An expired class that lost the report slot holds at the limit and fires later.
        if ((infly[i] == '0) || ret_hit[i] || q_pop[i] || tmo_fire[i]) wd[i] <= '0;
        else if (!expire[i])                                            wd[i] <= wd[i] + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_rty_grant_sched.sv
// Self-checking bench: queue-based reference model compared every cycle, plus directed literals.
module tb_rty_grant_sched;
  import rty_pkg::*;

  localparam int NQ  = DEF_QOS_CLASS;
  localparam int QW  = $clog2(NQ);
  localparam int SW  = DEF_SRC_NODE_W;
  localparam int CW  = $clog2(DEF_MAX_INFLY) + 1;
  localparam int TMO = DEF_TIMEOUT_CYC;

  logic             clk = 1'b0, rst_n = 1'b0;
  logic             enq_vld = 1'b0, enq_rdy;
  logic [QW-1:0]    enq_qos = '0;
  logic [SW-1:0]    enq_src = '0;
  logic [NQ-1:0]    cls_free = '0;
  logic             grant_vld, grant_rdy = 1'b0;
  logic [QW-1:0]    grant_qos;
  logic [SW-1:0]    grant_des_id;
  logic             ret_vld = 1'b0;
  logic [QW-1:0]    ret_qos = '0;
  logic [NQ*CW-1:0] infly_cnt;
  logic             tmo_pulse, ret_err;
  logic [QW-1:0]    tmo_qos;

  always #5 clk = ~clk;

  rty_grant_sched dut (
    .clk(clk), .rst_n(rst_n),
    .enq_vld(enq_vld), .enq_rdy(enq_rdy), .enq_qos(enq_qos), .enq_src(enq_src),
    .cls_free(cls_free),
    .grant_vld(grant_vld), .grant_rdy(grant_rdy), .grant_qos(grant_qos), .grant_des_id(grant_des_id),
    .ret_vld(ret_vld), .ret_qos(ret_qos),
    .infly_cnt(infly_cnt), .tmo_pulse(tmo_pulse), .tmo_qos(tmo_qos), .ret_err(ret_err)
  );

  int n_vec = 0, n_err = 0;

  task automatic check(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, act, exp);
    end
  endtask

  function automatic int inf(input int c);
    return int'(infly_cnt[c*CW +: CW]);
  endfunction

  // Reference model: plain queues and counters advanced by the rules, one call per edge.
  int mq [NQ][$];
  int m_inf [NQ], m_age [NQ], m_wd [NQ];
  int m_gv, m_gq, m_gd, m_tmo, m_tq, m_err;

  task automatic model_step();
    int  eq, rq, win, tmo_c;
    bit  open, enq_ok, popped, ret_i;
    bit  elig [NQ];
    eq   = int'(enq_qos);
    rq   = int'(ret_qos);
    open = (m_gv == 0) || grant_rdy;
    for (int i = 0; i < NQ; i++)
      elig[i] = (mq[i].size() > 0) && cls_free[i] && (m_inf[i] < DEF_MAX_INFLY);
    win = -1;
    for (int i = NQ - 1; i >= 0; i--) if (win < 0 && elig[i] && m_age[i] == DEF_AGE_LIMIT) win = i;
    for (int i = NQ - 1; i >= 0; i--) if (win < 0 && elig[i]) win = i;
    enq_ok = enq_vld && (mq[eq].size() < DEF_Q_DEPTH);
    tmo_c = -1;
    for (int i = 0; i < NQ; i++)
      if (tmo_c < 0 && m_wd[i] == TMO - 1 && !(ret_vld && rq == i)) tmo_c = i;
    m_err = (ret_vld && m_inf[rq] == 0) ? 1 : 0;
    m_tmo = (tmo_c >= 0) ? 1 : 0;
    if (tmo_c >= 0) m_tq = tmo_c;
    if (open) begin
      if (win >= 0) begin
        m_gv = 1;
        m_gq = win;
        m_gd = mq[win].pop_front();
      end else m_gv = 0;
    end
    for (int i = 0; i < NQ; i++) begin
      popped = open && (win == i);
      ret_i  = ret_vld && (rq == i);
      if (m_inf[i] == 0 || ret_i || popped || tmo_c == i) m_wd[i] = 0;
      else if (m_wd[i] < TMO - 1) m_wd[i]++;
      m_inf[i] += (popped ? 1 : 0) - (((ret_i && m_inf[i] > 0) || tmo_c == i) ? 1 : 0);
      if (open) begin
        if (!elig[i] || win == i) m_age[i] = 0;
        else if (m_age[i] < DEF_AGE_LIMIT) m_age[i]++;
      end
    end
    if (enq_ok) mq[eq].push_back(int'(enq_src));
  endtask

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NQ; i++) begin
        mq[i].delete();
        m_inf[i] = 0; m_age[i] = 0; m_wd[i] = 0;
      end
      m_gv = 0; m_gq = 0; m_gd = 0; m_tmo = 0; m_tq = 0; m_err = 0;
    end else model_step();
  end

  always @(negedge clk) begin
    check("m_grant_vld", int'(grant_vld), m_gv);
    if (m_gv != 0) begin
      check("m_grant_qos", int'(grant_qos), m_gq);
      check("m_grant_des", int'(grant_des_id), m_gd);
    end
    for (int i = 0; i < NQ; i++) check("m_infly", inf(i), m_inf[i]);
    check("m_tmo_pulse", int'(tmo_pulse), m_tmo);
    if (m_tmo != 0) check("m_tmo_qos", int'(tmo_qos), m_tq);
    check("m_ret_err", int'(ret_err), m_err);
    check("m_enq_rdy", int'(enq_rdy), (mq[int'(enq_qos)].size() < DEF_Q_DEPTH) ? 1 : 0);
  end

  task automatic tick(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic idle();
    enq_vld = 1'b0; ret_vld = 1'b0;
  endtask

  task automatic do_reset();
    idle();
    rst_n = 1'b0;
    tick(2);
    rst_n = 1'b1;
    tick();
  endtask

  task automatic push(input int q, input int s);
    enq_vld = 1'b1; enq_qos = QW'(q); enq_src = SW'(s);
    tick();
    enq_vld = 1'b0;
  endtask

  task automatic check_grant(input string name, input int q, input int s);
    check({name, "_vld"}, int'(grant_vld), 1);
    check({name, "_qos"}, int'(grant_qos), q);
    check({name, "_des"}, int'(grant_des_id), s);
  endtask

  initial begin
    bit seen;
    do_reset();
    check("rst_grant_vld", int'(grant_vld), 0);
    check("rst_infly", int'(infly_cnt), 0);
    check("rst_tmo", int'(tmo_pulse), 0);
    check("rst_ret_err", int'(ret_err), 0);

    // Single grant path, no bypass
    cls_free = '1; grant_rdy = 1'b1;
    push(2, 1);
    check("single_no_bypass", int'(grant_vld), 0);
    tick();
    check_grant("single", 2, 1);
    check("single_infly2", inf(2), 1);
    ret_vld = 1'b1; ret_qos = 2'd2;
    tick();
    idle();
    check("single_ret_infly2", inf(2), 0);

    // Strict priority
    do_reset();
    cls_free = '0; grant_rdy = 1'b0;
    push(0, 2); push(1, 1); push(3, 3);
    cls_free = '1; grant_rdy = 1'b1;
    tick(); check_grant("prio_1st", 3, 3);
    tick(); check_grant("prio_2nd", 1, 1);
    tick(); check_grant("prio_3rd", 0, 2);

    // Aging: class 3 refilled every cycle, class 0 forced after 15 losses
    do_reset();
    cls_free = '0; grant_rdy = 1'b1;
    push(3, 0); push(3, 1); push(0, 2);
    cls_free = '1;
    enq_vld = 1'b1; enq_qos = 2'd3; ret_vld = 1'b1; ret_qos = 2'd3;
    seen = 1'b0;
    for (int k = 0; k < DEF_AGE_LIMIT; k++) begin
      enq_src = SW'($urandom_range(0, 3));
      tick();
      if (!grant_vld || grant_qos != 2'd3) seen = 1'b1;
    end
    check("aging_losses", int'(seen), 0);
    tick();
    check_grant("aging_forced", 0, 2);
    tick();
    check("aging_after", int'(grant_qos), 3);
    idle();

    // Backpressure hold, full queue, MAX_INFLY ineligibility
    do_reset();
    cls_free = '1; grant_rdy = 1'b0;
    push(1, 3);
    tick();
    check_grant("bp_load", 1, 3);
    seen = 1'b0;
    for (int k = 0; k < 10; k++) begin
      enq_vld = (k < 4); enq_qos = 2'd1; enq_src = SW'((k == 3) ? 0 : k);
      tick();
      if (!grant_vld || grant_qos != 2'd1 || grant_des_id != 2'd3) seen = 1'b1;
    end
    idle();
    check("bp_hold", int'(seen), 0);
    enq_qos = 2'd1; #1;
    check("full_enq_rdy1", int'(enq_rdy), 0);
    enq_qos = 2'd0; #1;
    check("full_enq_rdy0", int'(enq_rdy), 1);
    enq_vld = 1'b1; enq_qos = 2'd0; enq_src = 2'd2; grant_rdy = 1'b1;
    tick(); enq_vld = 1'b0;
    check_grant("cap_a", 1, 0);
    tick(); check_grant("cap_b", 1, 1);
    tick(); check_grant("cap_c", 1, 2);
    tick(); check_grant("cap_cls0", 0, 2);
    check("cap_infly1", inf(1), DEF_MAX_INFLY);

    // Timeout with no return, then with a return in the expiry cycle
    do_reset();
    cls_free = '1; grant_rdy = 1'b1;
    push(2, 1); tick();
    seen = 1'b0;
    repeat (TMO - 1) begin tick(); if (tmo_pulse) seen = 1'b1; end
    check("tmo_early", int'(seen), 0);
    tick();
    check("tmo_pulse", int'(tmo_pulse), 1);
    check("tmo_qos", int'(tmo_qos), 2);
    check("tmo_infly2", inf(2), 0);
    tick();
    check("tmo_one_cycle", int'(tmo_pulse), 0);
    push(2, 3); tick();
    tick(TMO - 1);
    ret_vld = 1'b1; ret_qos = 2'd2;
    tick(); idle();
    check("tmo_ret_wins", int'(tmo_pulse), 0);
    check("tmo_ret_infly2", inf(2), 0);
    tick();
    check("tmo_ret_after", int'(tmo_pulse), 0);

    // Two classes expiring together: lower index first, the other one cycle later
    do_reset();
    cls_free = '1; grant_rdy = 1'b1;
    push(3, 0); push(3, 1); push(1, 2);
    ret_vld = 1'b1; ret_qos = 2'd3;
    tick(); idle();
    tick(TMO - 1);
    tick();
    check("tmo2_first", int'(tmo_pulse), 1);
    check("tmo2_first_qos", int'(tmo_qos), 1);
    tick();
    check("tmo2_second", int'(tmo_pulse), 1);
    check("tmo2_second_qos", int'(tmo_qos), 3);
    tick();
    check("tmo2_done", int'(tmo_pulse), 0);
    check("tmo2_infly", int'(infly_cnt), 0);

    // Return with nothing in flight
    do_reset();
    ret_vld = 1'b1; ret_qos = 2'd0;
    tick(); idle();
    check("ret_err_pulse", int'(ret_err), 1);
    check("ret_err_infly0", inf(0), 0);
    tick();
    check("ret_err_clear", int'(ret_err), 0);

    // Asynchronous reset mid-grant discards queued work
    do_reset();
    cls_free = '0; grant_rdy = 1'b0;
    push(1, 1); push(3, 2); push(3, 0);
    cls_free = 4'b0010;
    tick();
    check("mid_grant", int'(grant_vld), 1);
    #2 rst_n = 1'b0;
    #1 check("async_rst_vld", int'(grant_vld), 0);
    tick();
    cls_free = '1; grant_rdy = 1'b1; rst_n = 1'b1;
    seen = 1'b0;
    repeat (4) begin tick(); if (grant_vld) seen = 1'b1; end
    check("rst_queues_empty", int'(seen), 0);

    // Randomized traffic, frequent returns
    for (int c = 0; c < 3000; c++) begin
      enq_vld   = ($urandom_range(0, 1) == 1);
      enq_qos   = QW'($urandom_range(0, NQ - 1));
      enq_src   = SW'($urandom_range(0, 3));
      cls_free  = NQ'($urandom_range(0, 15));
      grant_rdy = ($urandom_range(0, 3) != 0);
      ret_vld   = ($urandom_range(0, 3) == 0);
      ret_qos   = QW'($urandom_range(0, NQ - 1));
      tick();
    end
    // Randomized traffic, rare returns so watchdogs expire
    for (int c = 0; c < 1500; c++) begin
      enq_vld   = ($urandom_range(0, 7) == 0);
      enq_qos   = QW'($urandom_range(0, NQ - 1));
      enq_src   = SW'($urandom_range(0, 3));
      cls_free  = NQ'($urandom_range(0, 15));
      grant_rdy = ($urandom_range(0, 1) == 1);
      ret_vld   = ($urandom_range(0, 199) == 0);
      ret_qos   = QW'($urandom_range(0, NQ - 1));
      tick();
    end
    idle();
    tick(2);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/rty_grant_sched.md
Name: rty_grant_sched

Overview:
- Schedules retry grants for the retry engine's parked requests.
- Holds per-QoS-class queues of source IDs whose requests were refused and parked for retry.
- Arbitrates among classes using strict priority with anti-starvation aging, and issues one grant at a time to a source node over a valid/ready channel.
- Tracks grants in flight per class and reclaims a grant's slot if the retried request does not return within a timeout.

Parameters:
- QOS_CLASS, 4, number of QoS classes; class index QOS_CLASS-1 has highest priority.
- SRC_NODE_W, 2, source node ID width.
- Q_DEPTH, 4, per-class pending-queue depth (power of 2).
- MAX_INFLY, 4, maximum outstanding grants per class.
- AGE_LIMIT, 15, number of cycles an eligible, unselected class waits before being forced.
- TIMEOUT_CYC, 100, number of cycles without a return before one in-flight grant of a class is reclaimed.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- enq_vld  in  1  retry-park event valid
- enq_rdy  out  1  queue for enq_qos not full
- enq_qos  in  $clog2(QOS_CLASS)  class of parked request
- enq_src  in  SRC_NODE_W  source node of parked request
- cls_free  in  QOS_CLASS  per-class: command buffer can accept one retried request
- grant_vld  out  1  grant valid (registered)
- grant_rdy  in  1  grant consumed
- grant_qos  out  $clog2(QOS_CLASS)  class of the current grant
- grant_des_id  out  SRC_NODE_W  destination source node of the grant
- ret_vld  in  1  a granted retry arrived back at the engine
- ret_qos  in  $clog2(QOS_CLASS)  class of the returning retry
- infly_cnt  out  QOS_CLASS*($clog2(MAX_INFLY)+1)  per-class outstanding grants, packed, class 0 in the LSBs
- tmo_pulse  out  1  one-cycle pulse when a grant is reclaimed
- tmo_qos  out  $clog2(QOS_CLASS)  class of the reclaimed grant
- ret_err  out  1  one-cycle pulse when ret_vld arrives for a class with infly==0

Behaviour:
- Reset (asynchronous, active-low):
  - All queues empty; all counters, age and watchdog registers 0.
  - grant_vld=0, grant_qos=0, grant_des_id=0, tmo_pulse=0, ret_err=0.
  - A reset mid-operation discards pending grants without any pulse.
- Enqueue:
  - enq_rdy is combinational: queue[enq_qos] not full.
  - A push happens when enq_vld&&enq_rdy.
  - A full queue refuses the push even if the same queue pops in that cycle.
- Eligibility of class i: queue i non-empty, cls_free[i]=1, and infly[i]<MAX_INFLY.
- Load slot: the output register may load when grant_vld==0 || grant_rdy==1.
- Arbitration (combinational, evaluated every cycle):
  - If any eligible class has age==AGE_LIMIT, pick the highest-index such class.
  - Otherwise pick the highest-index eligible class.
- Pop and grant load:
  - When the load slot is open and at least one class is eligible, pop the winner's head.
  - grant_vld<=1, grant_qos<=winner, grant_des_id<=popped src.
  - If the load slot is open and no class is eligible, grant_vld<=0.
  - If the load slot is closed (grant_vld=1, grant_rdy=0), grant_vld, grant_qos and grant_des_id hold.
- Latency: an entry pushed at edge E0 can appear on grant_vld at the earliest after edge E1. There is no bypass.
- Aging:
  - Each cycle the load slot is open, every eligible class that loses arbitration increments its age, saturating at AGE_LIMIT.
  - The winner's age clears to 0.
  - A class that is not eligible clears its age to 0.
  - While the slot is closed, ages hold.
- In-flight counts:
  - infly[i] increments on the pop of class i (at grant load, not at grant_rdy).
  - infly[i] decrements on ret_vld with ret_qos==i, or on a timeout of class i.
  - A simultaneous increment and decrement on the same class leaves infly unchanged.
  - ret_vld with infly[ret_qos]==0 leaves the count at 0 and pulses ret_err the next cycle.
- Watchdog (per class):
  - wd[i] counts while infly[i]>0.
  - wd[i] clears on ret_vld for class i, on any pop of class i, or when infly[i]==0.
  - When wd[i]==TIMEOUT_CYC-1 and no return for class i occurs in that cycle, decrement infly[i], clear wd[i], and drive tmo_pulse=1 with tmo_qos=i the next cycle.
  - If several classes time out in the same cycle, the lowest-index class is reported. The other classes hold their watchdog at TIMEOUT_CYC-1 and fire in subsequent cycles.
  - A return in the same cycle as the watchdog expiry wins: no timeout.
- Queue pointers are $clog2(Q_DEPTH)+1 bits; full/empty is detected by the MSB wrap compare.

Decomposition:
- Package rty_pkg:
  - qos_t typedef ($clog2(QOS_CLASS) bits) and src_t typedef.
  - Constants for QOS_CLASS, Q_DEPTH, MAX_INFLY, AGE_LIMIT and TIMEOUT_CYC defaults, shared with the retry engine.
- Sub-module rty_src_fifo:
  - Single-class synchronous FIFO of src_t with push/pop/full/empty.
  - Instantiated QOS_CLASS times.
- Arbitration, aging, in-flight counts and watchdogs live in the top module.

Test Plan:
- Single grant path:
  - Stimulus: reset, cls_free=4'hF, grant_rdy=1; enqueue (qos 2, src 1).
  - Required: grant_vld=1 with grant_qos=2, des_id=1 one cycle after the push edge; infly[2]=1.
- Strict priority:
  - Stimulus: enqueue classes 0, 1, 3 in back-to-back cycles with grant_rdy=0 until all are queued, then raise grant_rdy=1.
  - Required: grant order is 3, 1, 0.
- Aging:
  - Stimulus: keep class 3 continuously refilled and class 0 holding one entry, grant_rdy=1, AGE_LIMIT=15.
  - Required: class 0 is granted after exactly 15 losing open-slot cycles; its age then resets.
- Backpressure and capacity:
  - Stimulus: grant_rdy=0 for 10 cycles.
  - Required: grant_vld, qos and des_id hold stable.
  - Stimulus: fill class 1 with 4 entries.
  - Required: enq_rdy=0 for qos 1.
  - Stimulus: drive MAX_INFLY=4 returns-absent grants for class 1.
  - Required: class 1 becomes ineligible while class 0 is still granted.
- Timeout:
  - Stimulus: one class 2 grant and no return.
  - Required: tmo_pulse with tmo_qos=2 after TIMEOUT_CYC cycles; infly[2]=0.
  - Stimulus: repeat with ret_vld for class 2 in the expiry cycle.
  - Required: no tmo_pulse; infly[2]=0.
- Errors and reset:
  - Stimulus: ret_vld for class 0 with infly[0]=0.
  - Required: ret_err pulses; count stays 0.
  - Stimulus: assert rst_n=0 mid-grant.
  - Required: grant_vld drops asynchronously; all queues read empty after release.
